imm_decode_pipe: RTL

IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/imm_decode_core.sv | 41 ++++
 rtl/imm_decode_pipe.sv | 70 +++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV opcode constants and immediate format codes
package riscv_pkg;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
endpackage

// File: rtl/imm_decode_core.sv
// imm_decode_core: combinational RV immediate/format/illegal decode
module imm_decode_core
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);
  logic [31:0] imm32;
  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = FMT_I;
      OPC_OP_IMM_32: begin
        fmt     = (XLEN == 64) ? FMT_I : FMT_NONE;
        illegal = (XLEN != 64);
      end
      OPC_STORE:          fmt = FMT_S;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      OPC_SYSTEM:         fmt = (EN_ZICSR && instr[14]) ? FMT_Z : FMT_I;
      OPC_OP, OPC_OP_32:  fmt = FMT_NONE;
      default:            illegal = 1'b1;
    endcase
  end
  // every format is built as a 32-bit value whose bit 31 is the XLEN sign bit
  always_comb
    imm32 = (fmt == FMT_I) ? {{20{instr[31]}}, instr[31:20]} :
            (fmt == FMT_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            (fmt == FMT_B) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            (fmt == FMT_U) ? {instr[31:12], 12'b0} :
            (fmt == FMT_J) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            (fmt == FMT_Z) ? {27'b0, instr[19:15]} : 32'b0;
  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: immediate decode with a 2-entry skid buffer on valid/ready
module imm_decode_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] immediate_o,
  output logic [2:0]      imm_fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    imm_fmt_e        fmt;
    logic            illegal;
  } entry_t;
  state_e          state, state_nx;
  entry_t          head, tail, dec;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_ill, acc, con;
  imm_decode_core #(.XLEN(XLEN), .EN_ZICSR(EN_ZICSR)) u_core (
    .instr   (instruction_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );
  assign dec = '{imm: dec_imm, target: pc_i + dec_imm, fmt: dec_fmt, illegal: dec_ill};
  assign acc = in_valid_i & in_ready_o;
  assign con = out_valid_o & out_ready_i;
  always_comb
    state_nx = flush_i          ? EMPTY :
               (state == EMPTY) ? (acc ? ONE : EMPTY) :
               (state == ONE)   ? ((acc && !con) ? FULL : (!acc && con) ? EMPTY : ONE) :
                                  (con ? ONE : FULL);
  // head is the oldest entry and drives the outputs directly
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state       <= EMPTY;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      head        <= '0;
      tail        <= '0;
    end else begin
      state       <= state_nx;
      in_ready_o  <= (state_nx != FULL);
      out_valid_o <= (state_nx != EMPTY);
      if (!flush_i) begin
        if (acc && (state == EMPTY || (state == ONE && con))) head <= dec;
        else if (con && state == FULL) head <= tail;
        if (acc && state == ONE && !con) tail <= dec;
      end
    end
  assign immediate_o = head.imm;
  assign target_o    = head.target;
  assign imm_fmt_o   = head.fmt;
  assign illegal_o   = head.illegal;
endmodule
